// File: rtl/vocab_writer_if.sv
// Handshake and RAM write-port bundle between the loader, vocab_writer and the vocab RAM.
interface vocab_writer_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
);
  logic                              cs;
  logic                              clear;
  logic                              word_valid;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
  logic                              word_ready;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_din;
  logic [ADDR_WIDTH-1:0]             count;
  logic                              overflow;
  logic                              done;

  modport slave (
    input  cs, clear, word_valid, word,
    output word_ready, mem_we, mem_addr, mem_din, count, overflow, done
  );

  modport master (
    output cs, clear, word_valid, word,
    input  word_ready, mem_we, mem_addr, mem_din, count, overflow, done
  );
endinterface

// File: rtl/vocab_writer.sv
// Writes packed words one char per cycle into the vocab RAM, keeping a trailing 0x00 end marker.
// Optional VOCAB_WRITER_CASE_FOLD_EN lower-cases 'A'-'Z' on the way into the RAM.
module vocab_writer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst_n,
  vocab_writer_if.slave bus
);
  localparam int IW = $clog2(WORD_LENGTH + 1);
  localparam logic [IW-1:0]         ONE_I   = IW'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   TWO_C   = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHAR = 3'd1,
    S_TERM = 3'd2,
    S_END  = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t                            state_r, state_s;
  logic [ADDR_WIDTH-1:0]             wp_r, count_r;
  logic [IW-1:0]                     idx_r, len_r, len_s;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_r;
  logic                              overflow_r, done_r;
  logic                              ready_s, accept_s, fits_s;
  logic [ADDR_WIDTH:0]               need_s, avail_s;
  logic                              mem_we_s;
  logic [ADDR_WIDTH-1:0]             mem_addr_s;
  logic [DATA_WIDTH-1:0]             mem_din_s;

  function automatic logic [IW-1:0] len_of(input logic [WORD_LENGTH*DATA_WIDTH-1:0] w);
    logic stop;
    len_of = '0;
    stop   = 1'b0;
    for (int k = 0; k < WORD_LENGTH; k++) begin
      if (!stop) begin
        if (w[(WORD_LENGTH-1-k)*DATA_WIDTH +: DATA_WIDTH] == '0) stop = 1'b1;
        else len_of = len_of + ONE_I;
      end
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] char_at(input logic [WORD_LENGTH*DATA_WIDTH-1:0] w,
                                                     input logic [IW-1:0] i);
    char_at = '0;
    for (int k = 0; k < WORD_LENGTH; k++) begin
      if (k == int'(i)) char_at = w[(WORD_LENGTH-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] c);
`ifdef VOCAB_WRITER_CASE_FOLD_EN
    if (c >= DATA_WIDTH'(8'h41) && c <= DATA_WIDTH'(8'h5A)) fold = c + DATA_WIDTH'(8'h20);
    else fold = c;
`else
    fold = c;
`endif
  endfunction

  // Reset gates ready so no word is offered an acceptance while the block is held in reset.
  assign ready_s  = rst_n & bus.cs & (state_r == S_IDLE) & ~bus.clear;
  assign accept_s = ready_s & bus.word_valid;
  assign len_s    = len_of(bus.word);
  assign need_s   = {{(ADDR_WIDTH + 1 - IW){1'b0}}, len_s} + TWO_C;
  assign avail_s  = DEPTH_C - {1'b0, wp_r};
  assign fits_s   = (need_s <= avail_s);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Next-state decode; clear wins over a simultaneous word.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.clear)                                      state_s = S_CLR;
        else if (accept_s && (len_s != '0) && fits_s)       state_s = S_CHAR;
        else                                                state_s = S_IDLE;
      end
      S_CHAR: begin
        if (idx_r == len_r - ONE_I) state_s = S_TERM;
        else                        state_s = S_CHAR;
      end
      S_TERM:  state_s = S_END;
      S_END:   state_s = S_IDLE;
      S_CLR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Write pointer, word capture, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r       <= '0;
      idx_r      <= '0;
      len_r      <= '0;
      word_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            word_r <= bus.word;
            len_r  <= len_s;
            idx_r  <= '0;
            if (len_s == '0) begin
              done_r <= 1'b1;
            end else if (!fits_s) begin
              overflow_r <= 1'b1;
              done_r     <= 1'b1;
            end
          end
        end
        S_CHAR: begin
          wp_r  <= wp_r + ONE_A;
          idx_r <= idx_r + ONE_I;
        end
        S_TERM: wp_r <= wp_r + ONE_A;
        // End marker sits at wp so the next word overwrites it.
        S_END: begin
          count_r <= count_r + ONE_A;
          done_r  <= 1'b1;
        end
        S_CLR: begin
          wp_r       <= '0;
          count_r    <= '0;
          overflow_r <= 1'b0;
        end
        default: wp_r <= wp_r;
      endcase
    end
  end

  // Moore RAM write port decoded from the registered state.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    mem_din_s  = '0;
    case (state_r)
      S_CHAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = wp_r;
        mem_din_s  = fold(char_at(word_r, idx_r));
      end
      S_TERM, S_END: begin
        mem_we_s   = 1'b1;
        mem_addr_s = wp_r;
      end
      S_CLR:   mem_we_s = 1'b1;
      default: mem_we_s = 1'b0;
    endcase
  end

  assign bus.word_ready = ready_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_din    = mem_din_s;
  assign bus.count      = count_r;
  assign bus.overflow   = overflow_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_vocab_writer.sv
// Bench for vocab_writer: directed table, reset/clear/cs corner cases, then random words vs a reference model.
module tb_vocab_writer;
  localparam int AW = 4, WL = 3, DW = 8, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vocab_writer_if #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW)) bus();
  vocab_writer #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];

  int m_wp, m_count;
  int m_ov;

  typedef struct { logic [23:0] w; int nwr; int cnt; int ov; } vec_t;
  vec_t tbl[7];

  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_din});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold_ref(input logic [7:0] c);
`ifdef VOCAB_WRITER_CASE_FOLD_EN
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
`else
    return c;
`endif
  endfunction

  // Reference: what the RAM should see for one offered word.
  task automatic model_word(input logic [23:0] w);
    logic [7:0] ch[3];
    int len;
    bit stop;
    ch[0] = w[23:16]; ch[1] = w[15:8]; ch[2] = w[7:0];
    len = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      if (!stop && ch[i] == 8'h00) stop = 1;
      else if (!stop) len++;
    end
    exp_q.delete();
    if (len == 0) begin
    end else if (m_wp + len + 2 > DEPTH) begin
      m_ov = 1;
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back({4'(m_wp + i), fold_ref(ch[i])});
      exp_q.push_back({4'(m_wp + len), 8'h00});
      exp_q.push_back({4'(m_wp + len + 1), 8'h00});
      m_wp += len + 1;
      m_count++;
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({name, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
  endtask

  task automatic run_word(input string name, input logic [23:0] w, output int nwr);
    bit got;
    bit rdy;
    got = 0; rdy = 0;
    @(negedge clk);
    bus.cs = 1'b1; bus.word = w; bus.word_valid = 1'b1;
    #1 check({name, "_ready"}, bus.word_ready, 1);
    @(posedge clk);
    #1 bus.word_valid = 1'b0; bus.word = 24'($urandom);
    model_word(w);
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin got = 1; rdy = bus.word_ready; end
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_ready_at_done"}, rdy, 1);
    @(negedge clk);
    check({name, "_done_pulse"}, bus.done, 0);
    nwr = obs_q.size();
    compare_writes(name);
    check({name, "_count"}, bus.count, m_count);
    check({name, "_overflow"}, bus.overflow, m_ov);
  endtask

  task automatic do_clear(input string name);
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    bus.clear = 1'b1; bus.cs = 1'b1;
    #1 check({name, "_ready_blocked"}, bus.word_ready, 0);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= (bus.done === 1'b1);
    end
    m_wp = 0; m_count = 0; m_ov = 0;
    exp_q.delete();
    exp_q.push_back({4'h0, 8'h00});
    compare_writes(name);
    check({name, "_no_done"}, saw_done, 0);
    check({name, "_count"}, bus.count, 0);
    check({name, "_overflow"}, bus.overflow, 0);
  endtask

  initial begin
    int nwr;
    logic [7:0] c[3];
    tbl[0] = '{24'h48656C, 5, 1, 0};  // "Hel"
    tbl[1] = '{24'h486900, 4, 2, 0};  // "Hi", third char after null ignored
    tbl[2] = '{24'h410000, 3, 3, 0};  // wp 7 -> 9
    tbl[3] = '{24'h616200, 4, 4, 0};  // wp 9 -> 12
    tbl[4] = '{24'h78797A, 0, 4, 1};  // needs 5, only 4 left
    tbl[5] = '{24'h6F6B00, 4, 5, 1};  // exactly fits: 12..15
    tbl[6] = '{24'h004142, 0, 5, 1};  // L=0

    bus.cs = 1'b0; bus.clear = 1'b0; bus.word_valid = 1'b0; bus.word = '0;
    m_wp = 0; m_count = 0; m_ov = 0;

    #1;
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.word_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_clear("clear0");

    for (int i = 0; i < 7; i++) begin
      run_word($sformatf("tbl%0d", i), tbl[i].w, nwr);
      check($sformatf("tbl%0d_nwr", i), nwr, tbl[i].nwr);
      check($sformatf("tbl%0d_cnt", i), bus.count, tbl[i].cnt);
      check($sformatf("tbl%0d_ov", i), bus.overflow, tbl[i].ov);
    end

    do_clear("clear1");

    // cs low: offered word must be neither accepted nor written.
    @(negedge clk);
    bus.cs = 1'b0; bus.word = 24'h48656C; bus.word_valid = 1'b1;
    #1 check("cs_low_ready", bus.word_ready, 0);
    repeat (3) @(negedge clk);
    bus.word_valid = 1'b0; bus.cs = 1'b1;
    check("cs_low_nwrites", obs_q.size(), 0);
    check("cs_low_count", bus.count, 0);

    // Reset in the middle of the char phase of "Hel".
    @(negedge clk);
    bus.word = 24'h48656C; bus.word_valid = 1'b1;
    @(posedge clk);
    #1 bus.word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", bus.mem_we, 0);
    check("midrst_ready", bus.word_ready, 0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_count", bus.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    m_wp = 0; m_count = 0; m_ov = 0;
    do_clear("clear2");
    run_word("hel_again", 24'h48656C, nwr);

    // Random words, occasional clears, against the reference model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear("rclear");
      end else begin
        for (int k = 0; k < 3; k++)
          c[k] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(32'h20, 32'h7E));
        run_word("rand", {c[0], c[1], c[2]}, nwr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
